herring_clock_ctrl: RTL and testbench
=====================================

# herring_clock_ctrl

Generates the 65C02 PHI2 clock (`cpu_clk_in`) from the 50 MHz board oscillator. It replaces the free-running counter tap with a phase state machine that has three functions: it stretches the high phase for accesses to the slow I/O window (ACIA/VIA, 0x8000–0x87FF), it halts the CPU with PHI2 held low, and it single-steps one bus cycle per `step` press. It sits in the decoder CPLD between `clk_src` and the CPU clock pin, alongside the chip-select logic.

## Interface
- `HALF_PERIOD`, 16: `clk_src` cycles per normal PHI2 phase (low and high). Range 1..65535.
- `IO_WAIT`, 24: extra `clk_src` cycles added to the high phase on an I/O-window access. Range 0..65535; 0 disables stretching.

- `clk_src`, in, 1: 50 MHz source clock; only clock domain.
- `reset_n`, in, 1: reset; asynchronous, active-low.
- `address`, in, [15:10]: CPU address bus, upper bits.
- `run`, in, 1: 1 = free-run, 0 = halt at the next cycle boundary. Level signal, already synchronous.
- `step`, in, 1: single-step request. Asynchronous (debounced button).
- `cpu_clk_in`, out, 1: PHI2 to the CPU. Registered.
- `halted`, out, 1: 1 while in HALT. Registered.
- `io_wait`, out, 1: 1 during the stretch portion of the high phase. Registered.

## Operation
- States: LOW, HIGH, STRETCH, HALT. `cpu_clk_in` = 1 in HIGH and STRETCH, 0 in LOW and HALT.
- Phase counter: 16 bits. It is cleared on every state entry and counts 0..N-1 within a state.
- LOW, on the last count (HALF_PERIOD-1):
  - Sample `io_hit = (address[15:11] == 5'b10000)` into a latch.
  - If `run` or `step_pending` is set: go to HIGH.
  - Otherwise: go to HALT.
- HIGH, on the last count:
  - If `io_hit` is latched and IO_WAIT > 0: go to STRETCH.
  - Otherwise: go to LOW.
- STRETCH: after IO_WAIT cycles, go to LOW. `io_wait` = 1 throughout.
- HALT: PHI2 is held low indefinitely (65C02 static core).
  - If `run` = 1 or `step_pending` = 1: re-sample `io_hit`, then go directly to HIGH. The low time has already been met.
- `step` path: 2-flop synchronizer, then rising-edge detect.
  - The edge sets `step_pending`.
  - `step_pending` is cleared on entry to HIGH.
  - While `run` = 1, the edge is discarded (pending is not set).
- Simultaneous events:
  - `run` falling during HIGH or STRETCH: the current cycle completes, then a full LOW, then HALT.
  - A step edge arriving in the same cycle as the HALT→HIGH transition is consumed by that transition. It does not cause a second step.

## Timing
- Reset values: state LOW, counter 0, `cpu_clk_in` 0, `halted` 0, `io_wait` 0, `step_pending` 0, `io_hit` 0, synchronizer flops 0.
- Normal cycle: 2·HALF_PERIOD `clk_src` cycles, 50% duty.
- I/O cycle: 2·HALF_PERIOD + IO_WAIT cycles; the high phase is HALF_PERIOD + IO_WAIT.
- Outputs change one `clk_src` edge after the state transition decision (registered); there is no combinational path to outputs.
- Address is sampled once per cycle, at the LOW→HIGH or HALT→HIGH decision edge. Address changes during HIGH are ignored.
- Step latency: 3–4 `clk_src` cycles from the `step` edge to `step_pending`, then 1 cycle to HIGH.
- `reset_n` assertion in any state (including mid-STRETCH) forces `cpu_clk_in` low immediately (async). LOW restarts from count 0 after release.

## Structure
- Shared package `herring_pkg`:
  - State encoding (2-bit).
  - `IO_WINDOW_PREFIX` = 5'b10000 and its width.
  - Phase counter width (16).
- One sub-module, `herring_sync_edge`: 2-flop synchronizer plus rising-edge pulse, async active-low reset. Reused for future button/IRQ inputs.
- Top contains the FSM, phase counter, and output registers only.

## Test plan
- Reset, `run`=1, HALF_PERIOD=4, IO_WAIT=6, address 0x0000 → `cpu_clk_in` period 8 cycles, 4 high / 4 low; `io_wait` never 1.
- Address 0x8400 held across the LOW end → high phase 10 cycles; `io_wait`=1 for exactly the last 6 of them; the next cycle with address 0x0000 has a 4-cycle high phase.
- Address 0x8800 → no stretch (outside the window). Address 0x8000 → stretch.
- `run`→0 mid-HIGH → current high completes, 4-cycle LOW, then `halted`=1 with `cpu_clk_in`=0 held for 100+ cycles. One `step` pulse → exactly one 4-cycle high phase, then back to HALT. A `step` held high for 50 cycles → still exactly one.
- `step` pulses while `run`=1 → no change to period; no extra cycle after a later halt.
- `reset_n` low mid-STRETCH → `cpu_clk_in`=0 and `io_wait`=0 without a clock edge. After release, the first high phase begins 4 cycles later.

Source files
------------

// File: rtl/herring_pkg.sv
// Shared definitions for the herring PHI2 clock controller: phase state encoding,
// phase counter width and the slow I/O window decode.
package herring_pkg;

  localparam int PHASE_CNT_W = 16;
  localparam int ADDR_HI_W   = 6;  // address[15:10] as seen by the CPLD
  localparam int IO_PREFIX_W = 5;
  localparam logic [IO_PREFIX_W-1:0] IO_WINDOW_PREFIX = 5'b10000;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_HIGH    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_HALT    = 2'd3
  } phase_state_e;

  // True for 0x8000-0x87FF; the don't-care bits are masked rather than dropped.
  function automatic logic in_io_window(input logic [ADDR_HI_W-1:0] addr_hi);
    logic [ADDR_HI_W-1:0] mask;
    logic [ADDR_HI_W-1:0] match;
    mask  = {{IO_PREFIX_W{1'b1}}, {(ADDR_HI_W-IO_PREFIX_W){1'b0}}};
    match = {IO_WINDOW_PREFIX, {(ADDR_HI_W-IO_PREFIX_W){1'b0}}};
    return (addr_hi & mask) == match;
  endfunction

endpackage

// File: rtl/herring_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// registered one-cycle rising-edge pulse.
module herring_sync_edge (
  input  logic clk_src,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  // [0],[1] are the synchronizer, [2] holds the previous synchronized level
  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/herring_clock_ctrl.sv
// 65C02 PHI2 generator: phase FSM with I/O-window high-phase stretching,
// halt with PHI2 held low, and single-step from a debounced button.
module herring_clock_ctrl
  import herring_pkg::*;
#(
  parameter int HALF_PERIOD = 16,
  parameter int IO_WAIT     = 24
) (
  input  logic         clk_src,
  input  logic         reset_n,
  input  logic [15:10] address,
  input  logic         run,
  input  logic         step,
  output logic         cpu_clk_in,
  output logic         halted,
  output logic         io_wait
);

  localparam logic [PHASE_CNT_W-1:0] PHASE_LAST   = PHASE_CNT_W'(HALF_PERIOD - 1);
  localparam logic [PHASE_CNT_W-1:0] STRETCH_LAST = PHASE_CNT_W'(IO_WAIT - 1);
  localparam logic                   STRETCH_EN   = (IO_WAIT > 0);

  phase_state_e           state_q, state_d;
  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   io_hit_q, io_hit_d;
  logic                   step_pending_q, step_pending_d;
  logic                   step_rise;
  logic                   enter_high;

  herring_sync_edge u_step_sync (
    .clk_src (clk_src),
    .reset_n (reset_n),
    .din     (step),
    .rise    (step_rise)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + PHASE_CNT_W'(1);
    io_hit_d       = io_hit_q;
    enter_high     = 1'b0;
    step_pending_d = step_pending_q;

    unique case (state_q)
      ST_LOW: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d    = '0;
          io_hit_d = in_io_window(address);
          if (run || step_pending_q) begin
            state_d    = ST_HIGH;
            enter_high = 1'b1;
          end else begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HIGH: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d   = '0;
          state_d = (io_hit_q && STRETCH_EN) ? ST_STRETCH : ST_LOW;
        end
      end
      ST_STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOW;
        end
      end
      ST_HALT: begin
        // Low time was already met before halting, so leave straight to HIGH.
        cnt_d = '0;
        if (run || step_pending_q) begin
          io_hit_d   = in_io_window(address);
          state_d    = ST_HIGH;
          enter_high = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_LOW;
      end
    endcase

    // A step edge coinciding with entry to HIGH is absorbed by that entry.
    if (enter_high) begin
      step_pending_d = 1'b0;
    end else if (step_rise && !run) begin
      step_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_LOW;
      cnt_q          <= '0;
      io_hit_q       <= 1'b0;
      step_pending_q <= 1'b0;
      cpu_clk_in     <= 1'b0;
      halted         <= 1'b0;
      io_wait        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      io_hit_q       <= io_hit_d;
      step_pending_q <= step_pending_d;
      cpu_clk_in     <= (state_d == ST_HIGH) || (state_d == ST_STRETCH);
      halted         <= (state_d == ST_HALT);
      io_wait        <= (state_d == ST_STRETCH);
    end
  end

endmodule

// File: tb/tb_herring_clock_ctrl.sv
// Bench for herring_clock_ctrl: directed scenarios plus random run/step/address
// traffic, compared cycle by cycle against a bus-cycle level reference model.
module tb_herring_clock_ctrl;

  localparam int HP = 4;
  localparam int IW = 6;
  // Expected output triple {cpu_clk_in, io_wait, halted}
  localparam logic [2:0] O_LOW  = 3'b000;
  localparam logic [2:0] O_HIGH = 3'b100;
  localparam logic [2:0] O_STR  = 3'b110;
  localparam logic [2:0] O_HALT = 3'b001;

  logic         clk_src = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:10] address = '0;
  logic         run     = 1'b0;
  logic         step    = 1'b0;
  logic         cpu_clk_in;
  logic         halted;
  logic         io_wait;

  herring_clock_ctrl #(.HALF_PERIOD(HP), .IO_WAIT(IW)) dut (
    .clk_src    (clk_src),
    .reset_n    (reset_n),
    .address    (address),
    .run        (run),
    .step       (step),
    .cpu_clk_in (cpu_clk_in),
    .halted     (halted),
    .io_wait    (io_wait)
  );

  always #5 clk_src = ~clk_src;

  int total = 0;
  int bad   = 0;

  // Model: queue of outputs for the coming edges of the current bus cycle
  logic [2:0] exp_q[$];
  logic [2:0] exp_now;
  logic       pend_m;
  logic [3:0] st_hist;

  int   rises, cur_hi, cur_iw, cur_lo, last_hi, last_iw, last_lo;
  logic prev_clk;

  logic [15:0] addr_tbl [5] = '{16'h0000, 16'h8000, 16'h8400, 16'h87FF, 16'h8800};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic in_window(input logic [15:10] a);
    logic [15:0] full;
    full = {a, 10'h000};
    return (full >= 16'h8000) && (full <= 16'h87FF);
  endfunction

  task automatic set_addr(input logic [15:0] a);
    address = a[15:10];
  endtask

  task automatic model_reset();
    exp_q.delete();
    repeat (HP - 1) exp_q.push_back(O_LOW);
    exp_now  = O_LOW;
    pend_m   = 1'b0;
    st_hist  = '0;
    rises    = 0;
    cur_hi   = 0;
    cur_iw   = 0;
    cur_lo   = 0;
    last_hi  = 0;
    last_iw  = 0;
    last_lo  = 0;
    prev_clk = 1'b0;
  endtask

  // Advance the model by one clk_src edge using the inputs about to be sampled.
  task automatic model_edge();
    logic rise_seen;
    logic go_high;
    rise_seen = st_hist[2] & ~st_hist[3];  // step edge becomes visible 3 edges later
    go_high   = 1'b0;
    if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
    end else if (run || pend_m) begin
      go_high = 1'b1;
      exp_now = O_HIGH;
      repeat (HP - 1) exp_q.push_back(O_HIGH);
      if (in_window(address)) repeat (IW) exp_q.push_back(O_STR);
      repeat (HP) exp_q.push_back(O_LOW);
    end else begin
      exp_now = O_HALT;
    end
    if (go_high) pend_m = 1'b0;
    else if (rise_seen && !run) pend_m = 1'b1;
    st_hist = {st_hist[2:0], step};
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_src);
    #1;
    chk("phase", 32'({cpu_clk_in, io_wait, halted}), 32'(exp_now));
    if (cpu_clk_in) begin
      if (!prev_clk) begin
        rises++;
        last_lo = cur_lo;
        cur_hi  = 0;
        cur_iw  = 0;
      end
      cur_hi++;
      if (io_wait) cur_iw++;
    end else begin
      if (prev_clk) begin
        last_hi = cur_hi;
        last_iw = cur_iw;
        cur_lo  = 0;
      end
      cur_lo++;
    end
    prev_clk = cpu_clk_in;
    @(negedge clk_src);
  endtask

  task automatic wait_for(input logic [2:0] want, input string tag);
    int n;
    n = 0;
    while (exp_now != want && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk_src);
    chk("rst_clk", 32'(cpu_clk_in), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_iowait", 32'(io_wait), 32'd0);

    // Free run, address outside the window
    run = 1'b1;
    reset_n = 1'b1;
    model_reset();
    repeat (40) cyc();
    chk("norm_hi", last_hi, HP);
    chk("norm_lo", last_lo, HP);
    chk("norm_iw", last_iw, 0);

    // Stretched cycle, then an unstretched one
    set_addr(16'h8400);
    wait_for(O_STR, "wait_str");
    set_addr(16'h0000);
    wait_for(O_LOW, "wait_low1");
    chk("io_hi", last_hi, HP + IW);
    chk("io_iw", last_iw, IW);
    wait_for(O_HIGH, "wait_hi1");
    wait_for(O_LOW, "wait_low2");
    chk("after_io_hi", last_hi, HP);

    set_addr(16'h8800);
    repeat (3 * (2 * HP + IW)) cyc();
    chk("x8800_hi", last_hi, HP);
    chk("x8800_iw", last_iw, 0);
    set_addr(16'h8000);
    repeat (3 * (2 * HP + IW)) cyc();
    chk("x8000_hi", last_hi, HP + IW);
    chk("x8000_iw", last_iw, IW);

    // Halt requested mid-HIGH
    set_addr(16'h0000);
    wait_for(O_LOW, "wait_low3");
    wait_for(O_HIGH, "wait_hi2");
    cyc();
    run = 1'b0;
    rises = 0;
    repeat (120) cyc();
    chk("halt_rises", rises, 0);
    chk("halt_hi", last_hi, HP);
    chk("halt_flag", 32'(halted), 32'd1);

    // Single step: short pulse, then a long press
    rises = 0;
    step = 1'b1;
    repeat (3) cyc();
    step = 1'b0;
    repeat (60) cyc();
    chk("step_rises", rises, 1);
    chk("step_hi", last_hi, HP);
    chk("step_halt", 32'(halted), 32'd1);
    rises = 0;
    step = 1'b1;
    repeat (50) cyc();
    step = 1'b0;
    repeat (30) cyc();
    chk("hold_rises", rises, 1);

    // Steps while running are discarded
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) step = ~step;
      cyc();
    end
    chk("run_step_hi", last_hi, HP);
    chk("run_step_lo", last_lo, HP);
    step = 1'b0;
    repeat (10) cyc();
    run = 1'b0;
    repeat (30) cyc();
    rises = 0;
    repeat (80) cyc();
    chk("run_step_extra", rises, 0);

    // Async reset in the middle of a stretch
    run = 1'b1;
    set_addr(16'h8000);
    wait_for(O_STR, "wait_str2");
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_clk", 32'(cpu_clk_in), 32'd0);
    chk("arst_iowait", 32'(io_wait), 32'd0);
    @(negedge clk_src);
    set_addr(16'h0000);
    reset_n = 1'b1;
    model_reset();
    k = 0;
    while (rises == 0 && k < 20) begin
      cyc();
      k++;
    end
    chk("arst_first_hi", k, HP);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      if ($urandom_range(63) == 0) run = ~run;
      if ($urandom_range(7) == 0) step = ~step;
      if ($urandom_range(3) == 0) begin
        sel = int'($urandom_range(5));
        if (sel == 5) set_addr(16'($urandom));
        else set_addr(addr_tbl[sel]);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
